// File: rtl/mseq_tx.sv
// mseq_tx: transmit end of the m-sequence correlation link.
//
// On a send request a 3-bit Fibonacci LFSR produces one 7-chip
// maximal-length code word.  The word is presented in parallel together
// with a one-cycle start pulse for the correlator.  It is then serialized
// MSB-first, each chip held for CHIP_DIV clocks, for the requested number
// of code periods.  A one-cycle done pulse closes the transfer.
//
// Parameters
//   CHIP_DIV   clock cycles per chip, 1..16
//   SEED       LFSR seed loaded at every generation (3'b000 maps to 3'b001)
//
// Ports
//   clk         system clock, rising edge
//   nRst        synchronous active-low reset
//   send        transmit request, sampled in IDLE only
//   repeats     code periods to send, latched on accept (0 means 1)
//   busy        high in every state but IDLE
//   m_sequence  generated code word, bit[6] is the first chip
//   seq_ready   m_sequence valid, from SYNC until the next accepted send
//   start_out   one-cycle correlator start pulse in SYNC
//   chip_out    current serial chip, 0 outside TX
//   chip_valid  high on the first cycle of every chip
//   done        one-cycle completion pulse
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for send; code word and seq_ready hold
// GEN    | 7 cycles, LFSR output shifted into the code register
// SYNC   | 1 cycle, word complete, start pulse to correlator
// TX     | serialize 7*R chips, CHIP_DIV cycles per chip
// DONE   | 1 cycle completion pulse, back to IDLE

module mseq_tx #(
    parameter int          CHIP_DIV = 4,
    parameter logic [2:0]  SEED     = 3'b001
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        send,
    input  logic [3:0]  repeats,
    output logic        busy,
    output logic [6:0]  m_sequence,
    output logic        seq_ready,
    output logic        start_out,
    output logic        chip_out,
    output logic        chip_valid,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GEN  = 3'd1,
        S_SYNC = 3'd2,
        S_TX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 3'b001.
    localparam logic [2:0] SEED_EFF = (SEED == 3'b000) ? 3'b001 : SEED;
    localparam logic [3:0] DIV_LAST = 4'(CHIP_DIV - 1);

    state_t      state_q,     state_d;
    logic [2:0]  gen_cnt_q,   gen_cnt_d;
    logic [3:0]  div_cnt_q,   div_cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [4:0]  rep_cnt_q,   rep_cnt_d;
    logic [4:0]  rep_tgt_q,   rep_tgt_d;
    logic [2:0]  lfsr_q,      lfsr_d;
    logic [6:0]  code_q,      code_d;
    logic        seq_ready_q, seq_ready_d;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= S_IDLE;
            gen_cnt_q   <= 3'd0;
            div_cnt_q   <= 4'd0;
            bit_idx_q   <= 3'd0;
            rep_cnt_q   <= 5'd0;
            rep_tgt_q   <= 5'd0;
            lfsr_q      <= 3'd0;
            code_q      <= 7'd0;
            seq_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_cnt_q   <= gen_cnt_d;
            div_cnt_q   <= div_cnt_d;
            bit_idx_q   <= bit_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_tgt_q   <= rep_tgt_d;
            lfsr_q      <= lfsr_d;
            code_q      <= code_d;
            seq_ready_q <= seq_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gen_cnt_d   = gen_cnt_q;
        div_cnt_d   = div_cnt_q;
        bit_idx_d   = bit_idx_q;
        rep_cnt_d   = rep_cnt_q;
        rep_tgt_d   = rep_tgt_q;
        lfsr_d      = lfsr_q;
        code_d      = code_q;
        seq_ready_d = seq_ready_q;

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    rep_tgt_d   = (repeats == 4'd0) ? 5'd1 : {1'b0, repeats};
                    lfsr_d      = SEED_EFF;
                    gen_cnt_d   = 3'd0;
                    seq_ready_d = 1'b0;
                    state_d     = S_GEN;
                end
            end

            S_GEN: begin
                // First emitted bit ends up in code[6] after seven shifts.
                code_d = {code_q[5:0], lfsr_q[0]};
                lfsr_d = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[2:1]};
                if (gen_cnt_q == 3'd6) begin
                    gen_cnt_d   = 3'd0;
                    seq_ready_d = 1'b1;
                    state_d     = S_SYNC;
                end else begin
                    gen_cnt_d = gen_cnt_q + 3'd1;
                end
            end

            S_SYNC: begin
                div_cnt_d = 4'd0;
                bit_idx_d = 3'd6;
                rep_cnt_d = 5'd1;
                state_d   = S_TX;
            end

            S_TX: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = 4'd0;
                    if (bit_idx_q == 3'd0) begin
                        if (rep_cnt_q == rep_tgt_q) begin
                            state_d = S_DONE;
                        end else begin
                            bit_idx_d = 3'd6;
                            rep_cnt_d = rep_cnt_q + 5'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign m_sequence = code_q;
    assign seq_ready  = seq_ready_q;
    assign start_out  = (state_q == S_SYNC);
    assign chip_out   = (state_q == S_TX) ? code_q[bit_idx_q] : 1'b0;
    assign chip_valid = (state_q == S_TX) && (div_cnt_q == 4'd0);
    assign done       = (state_q == S_DONE);

endmodule
